semaforos_abc_ctrl: RTL and testbench

Sequential controller for the three-way A/B/C intersection. It replaces the purely combinational sensor-to-light mapping with timed phases: green, yellow, all-red. Demand is latched per approach, and approaches are served in round-robin order. It sits between the vehicle sensors ABC and the nine lamp drivers.

---
 rtl/semaforos_abc_ctrl.sv | 167 ++++++++++++++++
 tb/tb_semaforos_abc_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/semaforos_abc_ctrl.sv
// Timed traffic-light controller for the three-way A/B/C intersection.
// Each approach that receives the green goes through three phases in turn:
// green, then yellow, then all-red. Demand is latched per approach, and
// approaches are served in round-robin order A -> B -> C -> A.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high
//   ABC[2:0]       vehicle sensors (level); bit2=A, bit1=B, bit0=C
//   VDx/VAx/VMx    green/yellow/red lamp for approach x (registered)
//   pend[2:0]      latched pending requests, same bit order as ABC
//   fase[1:0]      00=GREEN, 01=YELLOW, 10=ALLRED
module semaforos_abc_ctrl #(
  parameter int unsigned T_GREEN_MIN = 4,
  parameter int unsigned T_GREEN_MAX = 12,
  parameter int unsigned T_YELLOW    = 2,
  parameter int unsigned T_ALLRED    = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] ABC,
  output logic       VDA,
  output logic       VAA,
  output logic       VMA,
  output logic       VDB,
  output logic       VAB,
  output logic       VMB,
  output logic       VDC,
  output logic       VAC,
  output logic       VMC,
  output logic [2:0] pend,
  output logic [1:0] fase
);

  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(T_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(T_ALLRED - 1);

  // Approaches are identified by their bit position in ABC: A=2, B=1, C=0.
  localparam logic [1:0] OWN_A = 2'd2;
  localparam logic [1:0] OWN_B = 2'd1;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    ALLRED = 2'b10
  } fase_t;

  fase_t            fase_q, fase_n;
  logic [1:0]       owner_q, owner_n;
  logic [1:0]       next_q, next_n;
  logic [CNT_W-1:0] timer_q, timer_n;
  logic [2:0]       pend_q, pend_n;
  logic [2:0]       vd_q, va_q, vm_q;
  logic [2:0]       vd_n, va_n, vm_n;

  logic [2:0]       own_mask;
  logic             own_req;
  logic             other_req;
  logic             handover;
  logic [1:0]       cand1, cand2;

  // Round-robin successor: A(2) -> B(1) -> C(0) -> A(2).
  function automatic logic [1:0] rr_succ(input logic [1:0] i);
    return (i == 2'd0) ? 2'd2 : i - 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  // Request qualification for the current owner.
  always_comb begin
    own_mask  = onehot(owner_q);
    own_req   = |(ABC & own_mask);
    other_req = |(pend_q & ~own_mask);
    handover  = other_req &&
                ((!own_req && timer_q >= GMIN_LAST) || timer_q >= GMAX_LAST);
    cand1     = rr_succ(owner_q);
    cand2     = rr_succ(cand1);
  end

  // Next-state logic for phase, owner, timer and pending latch, plus lamp decode.
  always_comb begin
    fase_n  = fase_q;
    owner_n = owner_q;
    next_n  = next_q;
    timer_n = timer_q + CNT_W'(1);
    // The green owner cannot latch its own demand; everyone else can.
    pend_n  = pend_q | (ABC & ~((fase_q == GREEN) ? own_mask : 3'b000));

    case (fase_q)
      GREEN: begin
        if (handover) begin
          fase_n  = YELLOW;
          timer_n = '0;
          // The owner's bit is always clear in GREEN, so cand2 is the only
          // alternative when cand1 has no pending demand.
          next_n  = pend_q[cand1] ? cand1 : cand2;
        end else if (timer_q >= GMAX_LAST) begin
          timer_n = timer_q;
        end
      end
      YELLOW: begin
        if (timer_q == Y_LAST) begin
          fase_n  = ALLRED;
          timer_n = '0;
        end
      end
      ALLRED: begin
        if (timer_q == AR_LAST) begin
          fase_n  = GREEN;
          timer_n = '0;
          owner_n = next_q;
          // Entering green clears the demand and wins over a same-cycle set.
          pend_n  = pend_n & ~onehot(next_q);
        end
      end
      default: begin
        fase_n  = GREEN;
        timer_n = '0;
      end
    endcase

    vd_n = (fase_n == GREEN)  ? onehot(owner_n) : 3'b000;
    va_n = (fase_n == YELLOW) ? onehot(owner_n) : 3'b000;
    vm_n = ~(vd_n | va_n);
  end

  // State and lamp registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fase_q  <= GREEN;
      owner_q <= OWN_A;
      next_q  <= OWN_B;
      timer_q <= '0;
      pend_q  <= '0;
      vd_q    <= 3'b100;
      va_q    <= 3'b000;
      vm_q    <= 3'b011;
    end else begin
      fase_q  <= fase_n;
      owner_q <= owner_n;
      next_q  <= next_n;
      timer_q <= timer_n;
      pend_q  <= pend_n;
      vd_q    <= vd_n;
      va_q    <= va_n;
      vm_q    <= vm_n;
    end
  end

  assign VDA  = vd_q[2];
  assign VAA  = va_q[2];
  assign VMA  = vm_q[2];
  assign VDB  = vd_q[1];
  assign VAB  = va_q[1];
  assign VMB  = vm_q[1];
  assign VDC  = vd_q[0];
  assign VAC  = va_q[0];
  assign VMC  = vm_q[0];
  assign pend = pend_q;
  assign fase = fase_q;

endmodule

// File: tb/tb_semaforos_abc_ctrl.sv
// Self-checking bench for semaforos_abc_ctrl: a directed vector table,
// hand-written multi-cycle sequences, and a random stream compared against
// a behavioural model through an expected-value queue.
module tb_semaforos_abc_ctrl;

  localparam int G_MIN = 4;
  localparam int G_MAX = 12;
  localparam int T_Y   = 2;
  localparam int T_AR  = 1;
  localparam int CW    = 8;

  // Lamp words {VDA,VAA,VMA, VDB,VAB,VMB, VDC,VAC,VMC}
  localparam logic [8:0] L_AG = 9'b100_001_001;
  localparam logic [8:0] L_AY = 9'b010_001_001;
  localparam logic [8:0] L_RR = 9'b001_001_001;
  localparam logic [8:0] L_CG = 9'b001_001_100;

  logic       clock;
  logic       reset;
  logic [2:0] ABC;
  logic       VDA, VAA, VMA, VDB, VAB, VMB, VDC, VAC, VMC;
  logic [2:0] pend;
  logic [1:0] fase;

  semaforos_abc_ctrl #(
    .T_GREEN_MIN(G_MIN),
    .T_GREEN_MAX(G_MAX),
    .T_YELLOW   (T_Y),
    .T_ALLRED   (T_AR),
    .CNT_W      (CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ABC  (ABC),
    .VDA  (VDA),
    .VAA  (VAA),
    .VMA  (VMA),
    .VDB  (VDB),
    .VAB  (VAB),
    .VMB  (VMB),
    .VDC  (VDC),
    .VAC  (VAC),
    .VMC  (VMC),
    .pend (pend),
    .fase (fase)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic [8:0] lamps;
    logic [2:0] pend;
    logic [1:0] fase;
  } obs_t;

  typedef struct packed {
    logic [2:0] abc;
    obs_t       exp;
  } vec_t;

  obs_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Behavioural model; approach index 0=A, 1=B, 2=C.
  int m_fase, m_t, m_owner, m_next;
  bit mp[3];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.lamps = {VDA, VAA, VMA, VDB, VAB, VMB, VDC, VAC, VMC};
    o.pend  = pend;
    o.fase  = fase;
    return o;
  endfunction

  function automatic int green_of();
    if (VDA) return 0;
    if (VDB) return 1;
    if (VDC) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_fase  = 0;
    m_t     = 0;
    m_owner = 0;
    m_next  = 1;
    for (int k = 0; k < 3; k++) mp[k] = 1'b0;
  endtask

  function automatic obs_t model_exp();
    obs_t       e;
    logic [2:0] l;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      if (m_fase == 0 && m_owner == k)      l = 3'b100;
      else if (m_fase == 1 && m_owner == k) l = 3'b010;
      else                                  l = 3'b001;
      e.lamps[8-3*k -: 3] = l;
    end
    e.pend = {mp[0], mp[1], mp[2]};
    e.fase = 2'(m_fase);
    return e;
  endfunction

  task automatic model_step(input logic [2:0] abc);
    bit req[3];
    bit np[3];
    bit other;
    int nf, nt, no, nn;
    req[0] = abc[2];
    req[1] = abc[1];
    req[2] = abc[0];
    other  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      np[k] = mp[k];
      if (req[k] && !(m_fase == 0 && k == m_owner)) np[k] = 1'b1;
      if (k != m_owner && mp[k]) other = 1'b1;
    end
    nf = m_fase; nt = m_t + 1; no = m_owner; nn = m_next;
    case (m_fase)
      0: begin
        if (other && ((!req[m_owner] && m_t >= G_MIN - 1) || m_t >= G_MAX - 1)) begin
          nf = 1;
          nt = 0;
          nn = mp[(m_owner + 1) % 3] ? (m_owner + 1) % 3 : (m_owner + 2) % 3;
        end else if (m_t >= G_MAX - 1) begin
          nt = m_t;
        end
      end
      1: if (m_t == T_Y - 1) begin nf = 2; nt = 0; end
      default: begin
        if (m_t == T_AR - 1) begin
          nf = 0;
          nt = 0;
          no = m_next;
          np[m_next] = 1'b0;
        end
      end
    endcase
    m_fase = nf; m_t = nt; m_owner = no; m_next = nn;
    for (int k = 0; k < 3; k++) mp[k] = np[k];
  endtask

  task automatic check_invariants();
    int nonred, sa, sb, sc;
    nonred = int'(!VMA) + int'(!VMB) + int'(!VMC);
    sa = int'(VDA) + int'(VAA) + int'(VMA);
    sb = int'(VDB) + int'(VAB) + int'(VMB);
    sc = int'(VDC) + int'(VAC) + int'(VMC);
    cmp("max_one_nonred_approach", 32'(nonred > 1), 32'(0));
    cmp("one_lamp_per_approach", 32'(sa == 1 && sb == 1 && sc == 1), 32'(1));
  endtask

  // One clock: drive input, queue the model's expectation, compare after the edge.
  task automatic cycle(input logic [2:0] abc);
    obs_t e, o;
    ABC = abc;
    model_step(abc);
    exp_q.push_back(model_exp());
    @(posedge clock);
    #1;
    o = observe();
    e = exp_q.pop_front();
    cmp("scoreboard", 32'(o), 32'(e));
    check_invariants();
  endtask

  // Raise reset mid-cycle and check the outputs before any clock edge.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1;
    cmp({tag, " lamps"}, 32'({VDA, VAA, VMA, VDB, VAB, VMB, VDC, VAC, VMC}), 32'(L_AG));
    cmp({tag, " pend"}, 32'(pend), 32'(3'b000));
    cmp({tag, " fase"}, 32'(fase), 32'(2'b00));
    model_reset();
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_next_green(input int exp_k, input string tag);
    int start, g;
    bit found;
    start = green_of();
    g     = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(3'b000);
      g = green_of();
      if (g != 3 && g != start) found = 1'b1;
    end
    cmp({tag, " reached"}, 32'(found), 32'(1));
    cmp({tag, " owner"}, 32'(g), 32'(exp_k));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   cnt;
    bit   done, found;
    int   wait_cnt[3];
    logic [1:0] prev_fase;

    reset = 1'b1;
    ABC   = 3'b000;
    model_reset();
    @(posedge clock);
    #1;

    // Reset state, then an idle hold: A keeps green with no yellow.
    apply_reset("reset");
    for (int i = 0; i < 50; i++) cycle(3'b000);
    cmp("idle hold lamps", 32'({VDA, VAA, VMA, VDB, VAB, VMB, VDC, VAC, VMC}), 32'(L_AG));
    cmp("idle hold fase", 32'(fase), 32'(2'b00));

    // Single C request: minimum green, yellow, all-red, C green.
    tbl[0] = '{abc: 3'b001, exp: '{lamps: L_AG, pend: 3'b001, fase: 2'b00}};
    tbl[1] = '{abc: 3'b000, exp: '{lamps: L_AG, pend: 3'b001, fase: 2'b00}};
    tbl[2] = '{abc: 3'b000, exp: '{lamps: L_AG, pend: 3'b001, fase: 2'b00}};
    tbl[3] = '{abc: 3'b000, exp: '{lamps: L_AY, pend: 3'b001, fase: 2'b01}};
    tbl[4] = '{abc: 3'b000, exp: '{lamps: L_AY, pend: 3'b001, fase: 2'b01}};
    tbl[5] = '{abc: 3'b000, exp: '{lamps: L_RR, pend: 3'b001, fase: 2'b10}};
    tbl[6] = '{abc: 3'b000, exp: '{lamps: L_CG, pend: 3'b000, fase: 2'b00}};
    apply_reset("reset before table");
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].abc);
      cmp($sformatf("vec%0d lamps", i),
          32'({VDA, VAA, VMA, VDB, VAB, VMB, VDC, VAC, VMC}), 32'(tbl[i].exp.lamps));
      cmp($sformatf("vec%0d pend", i), 32'(pend), 32'(tbl[i].exp.pend));
      cmp($sformatf("vec%0d fase", i), 32'(fase), 32'(tbl[i].exp.fase));
    end

    // A keeps requesting with C pending: green is capped at T_GREEN_MAX.
    apply_reset("reset before max green");
    cnt  = 1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      cycle(3'b101);
      if (VDA) cnt++;
      else done = 1'b1;
    end
    cmp("A green length under own demand", 32'(cnt), 32'(12));
    cmp("A yellow after max green", 32'(VAA), 32'(1));
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(3'b101);
      if (VDC) found = 1'b1;
    end
    cmp("C green after A max green", 32'(found), 32'(1));

    // Round-robin order: B before C, then A after C.
    apply_reset("reset before round robin");
    cycle(3'b000);
    cycle(3'b011);
    wait_next_green(1, "B first");
    cmp("pend during B green", 32'(pend), 32'(3'b001));
    wait_next_green(2, "C second");
    cycle(3'b100);
    cmp("A pending during C green", 32'(pend), 32'(3'b100));
    wait_next_green(0, "A after C");

    // Asynchronous reset during A yellow.
    apply_reset("reset before yellow");
    cycle(3'b010);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(3'b000);
      if (VAA) found = 1'b1;
    end
    cmp("A yellow reached", 32'(found), 32'(1));
    apply_reset("reset during yellow");

    // Random demand stream with service-latency tracking.
    for (int k = 0; k < 3; k++) wait_cnt[k] = 0;
    prev_fase = fase;
    for (int i = 0; i < 10000; i++) begin
      cycle(3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)));
      if (fase == 2'b00 && prev_fase == 2'b10) begin
        for (int k = 0; k < 3; k++) begin
          if (pend[2-k]) begin
            wait_cnt[k]++;
            cmp($sformatf("service bound approach %0d", k), 32'(wait_cnt[k] <= 9), 32'(1));
          end
        end
      end
      for (int k = 0; k < 3; k++) if (!pend[2-k]) wait_cnt[k] = 0;
      prev_fase = fase;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
